// File: rtl/timing_sequencer.sv
// Machine-cycle beat sequencer: produces one-hot W1/W2/W3 beats for a
// controller. Cycle length is 1, 2 or 3 beats depending on short/long, and
// the run halts at a cycle boundary on stop or step.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no beat active; waiting for a fresh rising edge on qd
//   W1     | first beat; short ends the cycle here
//   W2     | second beat; long extends the cycle to W3, otherwise it ends
//   W3     | third beat; the cycle always ends here
module timing_sequencer (
  input  logic        t3,
  input  logic        clr,
  input  logic        qd,
  input  logic        step,
  input  logic        stop,
  input  logic        short,
  input  logic        long,
  output logic        w1,
  output logic        w2,
  output logic        w3,
  output logic        running,
  output logic        cyc_done,
  output logic [15:0] cyc_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_W1   = 2'd1,
    S_W2   = 2'd2,
    S_W3   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        qd_q, qd_d;
  // armed_q goes high once qd has been seen low after reset, so a qd held
  // high through reset cannot be mistaken for a start request.
  logic        armed_q, armed_d;
  logic        w1_q, w1_d;
  logic        w2_q, w2_d;
  logic        w3_q, w3_d;
  logic        running_q, running_d;
  logic        cyc_done_q, cyc_done_d;
  logic [15:0] cyc_cnt_q, cyc_cnt_d;
  logic        qd_rise;
  logic        cyc_end;

  // Next-state, cycle-end detection and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    cyc_end    = 1'b0;
    qd_rise    = qd & ~qd_q & armed_q;
    qd_d       = qd;
    armed_d    = armed_q | ~qd;

    case (state_q)
      S_IDLE: if (qd_rise) state_d = S_W1;
      S_W1: begin
        if (short) cyc_end = 1'b1;
        else       state_d = S_W2;
      end
      S_W2: begin
        if (long) state_d = S_W3;
        else      cyc_end = 1'b1;
      end
      S_W3:    cyc_end = 1'b1;
      default: state_d = S_IDLE;
    endcase

    if (cyc_end) state_d = (stop | step) ? S_IDLE : S_W1;

    cyc_done_d = cyc_end;
    cyc_cnt_d  = cyc_cnt_q + {15'd0, cyc_end};

    // Beats are decoded from the next state and registered, so the outputs
    // come straight from flops with no input-to-output combinational path.
    w1_d      = (state_d == S_W1);
    w2_d      = (state_d == S_W2);
    w3_d      = (state_d == S_W3);
    running_d = (state_d != S_IDLE);
  end

  // State and output registers; clr clears everything immediately.
  always_ff @(posedge t3 or posedge clr) begin
    if (clr) begin
      state_q    <= S_IDLE;
      qd_q       <= 1'b0;
      armed_q    <= 1'b0;
      w1_q       <= 1'b0;
      w2_q       <= 1'b0;
      w3_q       <= 1'b0;
      running_q  <= 1'b0;
      cyc_done_q <= 1'b0;
      cyc_cnt_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      qd_q       <= qd_d;
      armed_q    <= armed_d;
      w1_q       <= w1_d;
      w2_q       <= w2_d;
      w3_q       <= w3_d;
      running_q  <= running_d;
      cyc_done_q <= cyc_done_d;
      cyc_cnt_q  <= cyc_cnt_d;
    end
  end

  assign w1       = w1_q;
  assign w2       = w2_q;
  assign w3       = w3_q;
  assign running  = running_q;
  assign cyc_done = cyc_done_q;
  assign cyc_cnt  = cyc_cnt_q;

endmodule

// File: tb/tb_timing_sequencer.sv
// Bench for timing_sequencer: directed scenarios followed by random stimulus,
// all checked against a beat-counting reference model.
module tb_timing_sequencer;

  logic        t3 = 1'b0;
  logic        clr, qd, step, stop, short, long;
  logic        w1, w2, w3, running, cyc_done;
  logic [15:0] cyc_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: beat number within the cycle (0 = idle), completed
  // cycle count, done flag and the start-edge history of qd.
  int m_beat;
  int m_cnt;
  bit m_done;
  bit m_prev_qd;
  bit m_seen_low;

  timing_sequencer dut (
    .t3(t3), .clr(clr), .qd(qd), .step(step), .stop(stop),
    .short(short), .long(long),
    .w1(w1), .w2(w2), .w3(w3), .running(running),
    .cyc_done(cyc_done), .cyc_cnt(cyc_cnt)
  );

  always #5 t3 = ~t3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_beat     = 0;
    m_cnt      = 0;
    m_done     = 0;
    m_prev_qd  = 0;
    m_seen_low = 0;
  endtask

  // One rising edge of the clock as seen by the model.
  task automatic model_step();
    bit rise;
    bit ends;
    if (clr) begin
      model_reset();
      return;
    end
    rise   = qd && !m_prev_qd && m_seen_low;
    m_done = 0;
    if (m_beat == 0) begin
      if (rise) m_beat = 1;
    end else begin
      ends = (m_beat == 1 && short) || (m_beat == 2 && !long) || (m_beat == 3);
      if (ends) begin
        m_cnt  = (m_cnt + 1) % 65536;
        m_done = 1;
        m_beat = (stop || step) ? 0 : 1;
      end else begin
        m_beat = m_beat + 1;
      end
    end
    if (!qd) m_seen_low = 1;
    m_prev_qd = qd;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ":w1"},       w1,       (m_beat == 1));
    chk({tag, ":w2"},       w2,       (m_beat == 2));
    chk({tag, ":w3"},       w3,       (m_beat == 3));
    chk({tag, ":running"},  running,  (m_beat != 0));
    chk({tag, ":cyc_done"}, cyc_done, m_done);
    chk({tag, ":cyc_cnt"},  cyc_cnt,  m_cnt);
  endtask

  task automatic tick(input string tag);
    @(posedge t3);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  // Called just after an edge: asserts clr between edges and checks that
  // the outputs clear without waiting for the clock. Leaves clr high.
  task automatic async_reset_check(input string tag);
    #1 clr = 1'b1;
    #1 model_reset();
    compare_all(tag);
  endtask

  initial begin
    clr = 1'b1; qd = 1'b1; step = 1'b0; stop = 1'b0; short = 1'b0; long = 1'b0;
    model_reset();
    #1;
    compare_all("rst0");
    ticks(2, "rst_clk");

    // qd held high through reset must not start a run.
    clr = 1'b0;
    ticks(3, "qd_held");
    chk("qd_held_idle", running, 0);
    qd = 1'b0; tick("qd_low");
    qd = 1'b1; tick("start");
    chk("start_w1", w1, 1);

    // Plain 2-beat cycles.
    ticks(6, "two_beat");
    chk("two_beat_cnt", cyc_cnt, 3);

    // short held: continuous W1, done every clock.
    short = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick("short");
      chk("short_w1", w1, 1);
      chk("short_done", cyc_done, 1);
    end

    // long: 3-beat cycles.
    short = 1'b0; long = 1'b1;
    ticks(7, "long");

    // step mode from a fresh reset.
    long = 1'b0; qd = 1'b0;
    async_reset_check("step_clr");
    #1 clr = 1'b0;
    tick("step_arm");
    step = 1'b1;
    qd = 1'b1; tick("step_go1");
    qd = 1'b0; ticks(2, "step_run1");
    chk("step_idle1", running, 0);
    chk("step_cnt1", cyc_cnt, 1);
    qd = 1'b1; tick("step_go2");
    qd = 1'b0; ticks(3, "step_run2");
    chk("step_cnt2", cyc_cnt, 2);
    step = 1'b0;

    // stop only honoured at the end-of-cycle edge.
    async_reset_check("stop_clr");
    #1 clr = 1'b0;
    tick("stop_arm");
    qd = 1'b1; tick("stop_go");
    stop = 1'b1; tick("stop_in_w1");
    stop = 1'b0; tick("stop_gone");
    chk("stop_no_halt", w1, 1);
    tick("stop_to_w2");
    stop = 1'b1; tick("stop_in_w2");
    chk("stop_halt", running, 0);
    stop = 1'b0; qd = 1'b0;

    // Counter wrap, then reset in W2.
    async_reset_check("wrap_clr");
    #1 clr = 1'b0;
    tick("wrap_arm");
    short = 1'b1;
    qd = 1'b1; tick("wrap_go");
    ticks(65535, "wrap_run");
    chk("wrap_ffff", cyc_cnt, 16'hFFFF);
    tick("wrap_edge");
    chk("wrap_zero", cyc_cnt, 0);
    tick("wrap_one");
    short = 1'b0; tick("wrap_w2");
    chk("wrap_in_w2", w2, 1);
    async_reset_check("w2_clr");
    chk("w2_clr_cnt", cyc_cnt, 0);
    chk("w2_clr_w2", w2, 0);
    #1 clr = 1'b0;

    // Random stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) qd = ~qd;
      short = ($urandom_range(0, 3) == 0);
      long  = ($urandom_range(0, 1) == 0);
      stop  = ($urandom_range(0, 7) == 0);
      step  = ($urandom_range(0, 9) == 0);
      tick("rnd");
      if ($urandom_range(0, 99) == 0) begin
        async_reset_check("rnd_clr");
        #1 clr = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timing_sequencer.md
TIMING_SEQUENCER -- requirements
Module: timing_sequencer

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 Port: t3 | input | 1 | system clock; all state updates on rising edge.
REQ-003 Port: clr | input | 1 | asynchronous reset, active-high.
REQ-004 Port: qd | input | 1 | start button, synchronous level; its rising edge starts a run.
REQ-005 Port: step | input | 1 | single-cycle mode: halt after every machine cycle.
REQ-006 Port: stop | input | 1 | controller request to halt at the end of the current machine cycle.
REQ-007 Port: short | input | 1 | controller request: current machine cycle ends after W1.
REQ-008 Port: long | input | 1 | controller request: current machine cycle extends to W3.
REQ-009 Port: w1, w2, w3 | output | 1 each | registered one-hot beat signals; all low when idle.
REQ-010 Port: running | output | 1 | high while any beat is active.
REQ-011 Port: cyc_done | output | 1 | one-clock pulse following each completed machine cycle.
REQ-012 Port: cyc_cnt | output | 16 | count of completed machine cycles.

Function
REQ-013 The state machine SHALL have four states: IDLE, W1, W2 and W3, with outputs decoded as w1=(W1), w2=(W2), w3=(W3) and running=(not IDLE).
REQ-014 A qd_q register SHALL sample qd on every edge, with qd_rise = qd & ~qd_q.
REQ-015 IDLE: if qd_rise, next state is W1; otherwise stay in IDLE.
REQ-016 W1: if short is 1, the cycle ends at this edge; otherwise next state is W2.
REQ-017 W2: if long is 1, next state is W3; otherwise the cycle ends at this edge.
REQ-018 W3: the cycle always ends at this edge; long has no effect in W3.
REQ-019 End of cycle: if (stop | step) is 1, next state is IDLE; otherwise next state is W1.
REQ-020 short and long are sampled only in W1 and W2 respectively; if both are high in W1, short wins.
REQ-021 stop and step are sampled only at the end-of-cycle edge; a stop pulse that does not overlap that edge is ignored.
REQ-022 qd_rise SHALL be ignored in W1, W2 and W3, so a run cannot restart mid-cycle.
REQ-023 At each end-of-cycle edge, cyc_cnt SHALL increment by 1, wrapping from 0xFFFF to 0x0000.
REQ-024 At each end-of-cycle edge, cyc_done SHALL be set to 1 for exactly one clock; otherwise it is 0.
REQ-025 Latency: the first W1 SHALL be asserted one clock after the edge at which qd_rise is seen.
REQ-026 Beats SHALL be glitch-free, registered outputs; no combinational path from any input to w1, w2, w3 or running.

Reset
REQ-027 While clr=1, the state SHALL be IDLE and w1=w2=w3=0, running=0, cyc_done=0, cyc_cnt=0x0000 and qd_q=0, regardless of t3.
REQ-028 Reset asserted mid-cycle (any state) SHALL take effect immediately, without completing the cycle or incrementing cyc_cnt.
REQ-029 After clr deasserts, the block SHALL remain in IDLE until a fresh qd rising edge; if qd is held high through reset, no start occurs until qd goes 0 then 1.

Verification
REQ-030 Scenario: reset, then qd 0→1 with short=long=stop=step=0 → beats W1,W2,W1,W2,…; after 3 cycles cyc_cnt=3.
REQ-031 Scenario: short=1 constantly → w1 stays high continuously; cyc_done=1 on every clock; cyc_cnt increments every clock.
REQ-032 Scenario: long=1 during W2 → sequence W1,W2,W3,W1; cyc_done pulses once per 3 clocks.
REQ-033 Scenario: step=1, qd pulse → exactly one W1,W2 then IDLE with running=0 and cyc_cnt=1; a second qd pulse → cyc_cnt=2.
REQ-034 Scenario: stop=1 only during W1 of a 2-beat cycle → no halt; stop=1 during W2 → IDLE after W2.
REQ-035 Scenario: preload cyc_cnt to 0xFFFF by running 65535 short cycles, then one more cycle → cyc_cnt=0x0000; clr asserted during W2 → all outputs 0 immediately and cyc_cnt=0.
